// File: rtl/rv_lsu.sv
// Load/store unit: one outstanding access on a word-wide request/grant/response bus.
// Define RV_LSU_MISALIGN_TRAP_EN to report misaligned accesses instead of truncating them.
module rv_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  mem_write,
    input  logic [2:0]            mem_op,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

`ifdef RV_LSU_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam logic [1:0] SZ_B = 2'b01;
    localparam logic [1:0] SZ_H = 2'b10;
    localparam logic [1:0] SZ_W = 2'b11;

    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    calc_be = 4'b0001 << off;
            SZ_H:    calc_be = 4'b0011 << {off[1], 1'b0};
            SZ_W:    calc_be = 4'b1111;
            default: calc_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SZ_B:    calc_wdata = {4{wd[7:0]}};
            SZ_H:    calc_wdata = {2{wd[15:0]}};
            SZ_W:    calc_wdata = wd;
            default: calc_wdata = 32'h0000_0000;
        endcase
    endfunction

    // Offset as actually used: half-words drop bit 0, words drop both bits.
    function automatic logic [1:0] eff_offset(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_H:    eff_offset = {off[1], 1'b0};
            SZ_W:    eff_offset = 2'b00;
            default: eff_offset = off;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                                input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] lane;
        lane = rd >> {off, 3'b000};
        case (size)
            SZ_B:    load_extend = uns ? {24'h00_0000, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            SZ_H:    load_extend = uns ? {16'h0000, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            SZ_W:    load_extend = lane;
            default: load_extend = 32'h0000_0000;
        endcase
    endfunction

    state_e                  state_q, state_d;
    logic                    req_ready_q, req_ready_d;
    logic                    busy_q, busy_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q, resp_err_d;
    logic                    bus_req_q, bus_req_d;
    logic                    bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
    logic [3:0]              bus_be_q, bus_be_d;
    logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [1:0]              off_q, off_d;

    logic                    op_ok_s;
    logic                    misalign_s;

    // Decode of the incoming command.
    always_comb begin
        op_ok_s    = (mem_op[1:0] != 2'b00) && (mem_op != 3'b111);
        misalign_s = ((mem_op[1:0] == SZ_H) && addr[0]) ||
                     ((mem_op[1:0] == SZ_W) && (addr[1:0] != 2'b00));
    end

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    size_d       = mem_op[1:0];
                    uns_d        = mem_op[2];
                    off_d        = eff_offset(mem_op[1:0], addr[1:0]);
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                    if (!op_ok_s) begin
                        state_d      = ST_DONE;
                        resp_valid_d = 1'b1;
                    end else if (TRAP_EN && misalign_s) begin
                        state_d      = ST_DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write;
                        bus_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
                        bus_be_d    = calc_be(mem_op[1:0], addr[1:0]);
                        bus_wdata_d = mem_write ? calc_wdata(mem_op[1:0], wdata) : '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus_gnt) begin
                    bus_req_d   = 1'b0;
                    bus_addr_d  = '0;
                    bus_be_d    = 4'b0000;
                    bus_wdata_d = '0;
                    if (bus_we_q) begin
                        state_d      = ST_DONE;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                    bus_we_d = 1'b0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (bus_rvalid) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_extend(size_q, uns_q, off_q, bus_rdata);
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset drops bus_req immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= 4'b0000;
            bus_wdata_q  <= '0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;

endmodule
